// File: rtl/br_resolve_unit_pkg.sv
// Shared types for the branch predictor and its training producer.
// Address width, BrInfo update bundle and resolve-unit FSM states.
package br_resolve_unit_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    logic  is_br;
    logic  taken;
  } br_entry_t;

  typedef struct packed {
    logic  valid;
    addr_t pc;
    logic  is_br;
    logic  taken;
  } br_info_t;

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    WAIT_FLUSH
  } rs_state_e;

endpackage

// File: rtl/br_resolve_unit_sync_fifo.sv
// Small in-order FIFO with combinational head read.
// Write while full is legal only when a read happens in the same cycle.
module br_resolve_unit_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  T                           wr_data,
  input  logic                       rd_en,
  output T                           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/br_resolve_unit.sv
// Buffers resolved branches, trains the predictor one BrInfo per cycle,
// and raises a one-cycle redirect on direction mispredicts.
module br_resolve_unit
  import br_resolve_unit_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exe_valid,
  output logic                  exe_ready,
  input  addr_t                 exe_pc,
  input  logic                  exe_is_br,
  input  logic                  exe_taken,
  input  logic                  exe_pred_taken,
  input  addr_t                 exe_target,
  input  logic                  upd_stall,
  output br_info_t              brinfo,
  output logic                  redirect_valid,
  output addr_t                 redirect_pc,
  input  logic                  flush_done,
  output logic [PERF_WIDTH-1:0] perf_br_count,
  output logic [PERF_WIDTH-1:0] perf_mispred_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic          full, empty;
  logic [CW-1:0] count;
  br_entry_t     head, in_entry;
  logic          accept, deq, bypass, enq, mis;
  addr_t         fix_pc;

  rs_state_e             state_q, state_d;
  addr_t                 redirect_pc_q, redirect_pc_d;
  br_info_t              brinfo_q, brinfo_d;
  logic [PERF_WIDTH-1:0] perf_br_q, perf_br_d;
  logic [PERF_WIDTH-1:0] perf_mis_q, perf_mis_d;

  assign deq       = !empty && !upd_stall;
  assign exe_ready = !full || deq || (state_q == WAIT_FLUSH);
  assign accept    = exe_valid && exe_ready && (state_q != WAIT_FLUSH);
  // Empty FIFO: skip it so the update lands one cycle after accept.
  assign bypass    = accept && (count == '0) && !upd_stall;
  assign enq       = accept && !bypass;

  assign in_entry.pc    = exe_pc;
  assign in_entry.is_br = exe_is_br;
  assign in_entry.taken = exe_is_br && exe_taken;

  assign mis = (exe_is_br && (exe_taken != exe_pred_taken)) ||
               (!exe_is_br && exe_pred_taken);
  assign fix_pc = (exe_is_br && exe_taken) ? exe_target
                                           : exe_pc + addr_t'(4);

  br_resolve_unit_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (br_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (enq),
    .wr_data (in_entry),
    .rd_en   (deq),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    brinfo_d = '0;
    if (deq) begin
      brinfo_d = '{valid: 1'b1, pc: head.pc,
                   is_br: head.is_br, taken: head.taken};
    end else if (bypass) begin
      brinfo_d = '{valid: 1'b1, pc: in_entry.pc,
                   is_br: in_entry.is_br, taken: in_entry.taken};
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      RUN: begin
        if (accept && mis) begin
          state_d       = REDIRECT;
          redirect_pc_d = fix_pc;
        end
      end
      REDIRECT:   state_d = flush_done ? RUN : WAIT_FLUSH;
      WAIT_FLUSH: if (flush_done) state_d = RUN;
      default:    state_d = RUN;
    endcase
  end

  always_comb begin
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    if (accept && exe_is_br && !(&perf_br_q))
      perf_br_d = perf_br_q + PERF_WIDTH'(1);
    if (accept && mis && !(&perf_mis_q))
      perf_mis_d = perf_mis_q + PERF_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      redirect_pc_q <= '0;
      brinfo_q      <= '0;
      perf_br_q     <= '0;
      perf_mis_q    <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      brinfo_q      <= brinfo_d;
      perf_br_q     <= perf_br_d;
      perf_mis_q    <= perf_mis_d;
    end
  end

  assign brinfo             = brinfo_q;
  assign redirect_valid     = (state_q == REDIRECT);
  assign redirect_pc        = redirect_pc_q;
  assign perf_br_count      = perf_br_q;
  assign perf_mispred_count = perf_mis_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed checks of br_resolve_unit with hand-computed expectations.
// Narrow perf counters make saturation reachable in a short run.
module tb_br_resolve_unit;
  import br_resolve_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          exe_valid;
  logic          exe_ready;
  addr_t         exe_pc;
  logic          exe_is_br;
  logic          exe_taken;
  logic          exe_pred_taken;
  addr_t         exe_target;
  logic          upd_stall;
  br_info_t      brinfo;
  logic          redirect_valid;
  addr_t         redirect_pc;
  logic          flush_done;
  logic [PW-1:0] perf_br_count;
  logic [PW-1:0] perf_mispred_count;

  int checks = 0;
  int errors = 0;

  br_resolve_unit #(
    .DEPTH      (DEPTH),
    .PERF_WIDTH (PW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .exe_valid          (exe_valid),
    .exe_ready          (exe_ready),
    .exe_pc             (exe_pc),
    .exe_is_br          (exe_is_br),
    .exe_taken          (exe_taken),
    .exe_pred_taken     (exe_pred_taken),
    .exe_target         (exe_target),
    .upd_stall          (upd_stall),
    .brinfo             (brinfo),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .flush_done         (flush_done),
    .perf_br_count      (perf_br_count),
    .perf_mispred_count (perf_mispred_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] bi(logic v, addr_t pc, logic b, logic t);
    return {v, pc, b, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(addr_t pc, logic b, logic t, logic p, addr_t tgt);
    exe_valid      = 1'b1;
    exe_pc         = pc;
    exe_is_br      = b;
    exe_taken      = t;
    exe_pred_taken = p;
    exe_target     = tgt;
    #1;
  endtask

  task automatic idle();
    exe_valid      = 1'b0;
    exe_pc         = '0;
    exe_is_br      = 1'b0;
    exe_taken      = 1'b0;
    exe_pred_taken = 1'b0;
    exe_target     = '0;
  endtask

  task automatic flush_pulse();
    flush_done = 1'b1;
    tick();
    flush_done = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    upd_stall  = 1'b0;
    flush_done = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_brinfo", brinfo, '0);
    check("rst_redir_v", redirect_valid, 0);
    check("rst_redir_pc", redirect_pc, 0);
    check("rst_br_cnt", perf_br_count, 0);
    check("rst_mis_cnt", perf_mispred_count, 0);
    check("rst_ready", exe_ready, 1);

    // correct prediction, bypass latency 1
    offer(32'h100, 1, 1, 1, 32'h500);
    tick();
    idle();
    check("ok_brinfo", brinfo, bi(1, 32'h100, 1, 1));
    check("ok_redir_v", redirect_valid, 0);
    check("ok_br_cnt", perf_br_count, 1);
    check("ok_mis_cnt", perf_mispred_count, 0);
    tick();
    check("ok_idle_v", brinfo.valid, 0);

    // not-taken mispredict, drop while waiting for flush
    offer(32'h200, 1, 0, 1, 32'h900);
    tick();
    idle();
    check("nt_redir_v", redirect_valid, 1);
    check("nt_redir_pc", redirect_pc, 32'h204);
    check("nt_brinfo", brinfo, bi(1, 32'h200, 1, 0));
    check("nt_mis_cnt", perf_mispred_count, 1);
    check("nt_br_cnt", perf_br_count, 2);
    tick();
    check("nt_redir_1cyc", redirect_valid, 0);
    offer(32'h204, 1, 1, 1, 32'h0);
    check("nt_wait_ready", exe_ready, 1);
    tick();
    check("nt_drop_v", brinfo.valid, 0);
    check("nt_drop_br", perf_br_count, 2);
    offer(32'h208, 1, 1, 1, 32'h0);
    flush_pulse();
    idle();
    check("nt_fd_drop_v", brinfo.valid, 0);
    check("nt_fd_drop_br", perf_br_count, 2);
    offer(32'h300, 1, 0, 0, 32'h0);
    tick();
    idle();
    check("nt_after_flush", brinfo, bi(1, 32'h300, 1, 0));
    check("nt_after_br", perf_br_count, 3);
    tick();

    // non-branch predicted taken
    offer(32'h40, 0, 0, 1, 32'h0);
    tick();
    idle();
    check("nb_redir_v", redirect_valid, 1);
    check("nb_redir_pc", redirect_pc, 32'h44);
    check("nb_brinfo", brinfo, bi(1, 32'h40, 0, 0));
    check("nb_br_cnt", perf_br_count, 3);
    check("nb_mis_cnt", perf_mispred_count, 2);
    flush_pulse();

    // taken target 0x8, flush_done during REDIRECT
    offer(32'h1000, 1, 1, 0, 32'h8);
    tick();
    idle();
    check("tg_redir_v", redirect_valid, 1);
    check("tg_redir_pc", redirect_pc, 32'h8);
    check("tg_brinfo", brinfo, bi(1, 32'h1000, 1, 1));
    flush_pulse();
    check("tg_redir_off", redirect_valid, 0);
    offer(32'h600, 1, 1, 1, 32'h0);
    check("tg_ready", exe_ready, 1);
    tick();
    idle();
    check("tg_next_acc", brinfo, bi(1, 32'h600, 1, 1));
    check("tg_br_cnt", perf_br_count, 5);
    check("tg_mis_cnt", perf_mispred_count, 3);
    tick();

    // pc+4 wraps at the address width
    offer(32'hFFFF_FFFC, 0, 0, 1, 32'h0);
    tick();
    idle();
    check("wr_redir_pc", redirect_pc, 32'h0);
    check("wr_mis_cnt", perf_mispred_count, 4);
    flush_pulse();

    // backpressure: 4 fill, 5th waits, full enq+deq on release
    upd_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(32'h700 + 32'(4 * i), 1, i[0], i[0], 32'h0);
      check($sformatf("bp_ready%0d", i), exe_ready, (i < 4) ? 1 : 0);
      if (i < 4) tick();
    end
    check("bp_stall_v", brinfo.valid, 0);
    upd_stall = 1'b0;
    #1;
    check("bp_rel_ready", exe_ready, 1);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_out%0d", i), brinfo,
            bi(1, 32'h700 + 32'(4 * i), 1, i[0]));
      tick();
    end
    check("bp_drained", brinfo.valid, 0);
    check("bp_br_sat", perf_br_count, 7);

    // mispredict counter saturates
    for (int i = 0; i < 4; i++) begin
      offer(32'h800, 0, 0, 1, 32'h0);
      tick();
      idle();
      flush_pulse();
    end
    check("sat_mis_cnt", perf_mispred_count, 7);

    // reset with three entries buffered
    upd_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'hA00 + 32'(4 * i), 1, 0, 0, 32'h0);
      tick();
    end
    idle();
    upd_stall = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mr_brinfo", brinfo, '0);
    check("mr_ready", exe_ready, 1);
    check("mr_mis_cnt", perf_mispred_count, 0);
    check("mr_redir_pc", redirect_pc, 0);
    tick();
    check("mr_empty1", brinfo.valid, 0);
    tick();
    check("mr_empty2", brinfo.valid, 0);
    offer(32'hB00, 1, 1, 1, 32'h0);
    tick();
    idle();
    check("mr_bypass", brinfo, bi(1, 32'hB00, 1, 1));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
